// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: fetches 16-bit instructions from a synchronous ROM and
// executes them against an accumulator and a register file. It supports
// branches, HALT, and valid/ready handshaked input and output ports.
module acc_cpu_core #(
  parameter int WIDTH = 16,
  parameter int REGS  = 16,
  parameter int PC_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [15:0]      imem_data,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             halted
);

  localparam int AW = $clog2(REGS);
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    FETCH,
    EXEC,
    IN_WAIT,
    OUT_WAIT,
    HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_AND   = 4'h5,
    OP_OR    = 4'h6,
    OP_XOR   = 4'h7,
    OP_SHL   = 4'h8,
    OP_SHR   = 4'h9,
    OP_JMP   = 4'hA,
    OP_JZ    = 4'hB,
    OP_IN    = 4'hC,
    OP_OUT   = 4'hD,
    OP_JN    = 4'hE,
    OP_HALT  = 4'hF
  } opcode_t;

  state_t           state, state_next;
  logic [PC_W-1:0]  pc, pc_next, pc_inc, jmp_target;
  logic [WIDTH-1:0] acc, acc_next, out_data_next;
  logic             out_valid_next, in_ready_next, halted_next;
  logic             reg_we;
  logic [WIDTH-1:0] regs [REGS];

  opcode_t          opcode;
  logic             imm_flag;
  logic [10:0]      operand;
  logic [AW-1:0]    reg_addr;
  logic [WIDTH-1:0] simm, op_val;
  logic [SW-1:0]    shamt;

  assign opcode     = opcode_t'(imem_data[15:12]);
  assign imm_flag   = imem_data[11];
  assign operand    = imem_data[10:0];
  assign reg_addr   = operand[AW-1:0];
  assign jmp_target = operand[PC_W-1:0];
  assign pc_inc     = pc + PC_W'(1);
  assign op_val     = imm_flag ? simm : regs[reg_addr];
  assign shamt      = op_val[SW-1:0];
  assign imem_addr  = pc;

  // The immediate is sign-extended from bit 10; narrow datapaths keep only the low bits.
  if (WIDTH > 11) begin : g_simm_ext
    assign simm = {{(WIDTH-11){operand[10]}}, operand};
  end else begin : g_simm_trunc
    assign simm = operand[WIDTH-1:0];
  end

  // Next-state and datapath decisions; everything holds unless the current state says otherwise.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    acc_next       = acc;
    out_data_next  = out_data;
    out_valid_next = out_valid;
    in_ready_next  = in_ready;
    halted_next    = halted;
    reg_we         = 1'b0;
    case (state)
      FETCH: state_next = EXEC;
      EXEC: begin
        pc_next    = pc_inc;
        state_next = FETCH;
        case (opcode)
          OP_NOP:   ;
          OP_LOAD:  acc_next = op_val;
          OP_STORE: reg_we = 1'b1;
          OP_ADD:   acc_next = acc + op_val;
          OP_SUB:   acc_next = acc - op_val;
          OP_AND:   acc_next = acc & op_val;
          OP_OR:    acc_next = acc | op_val;
          OP_XOR:   acc_next = acc ^ op_val;
          OP_SHL:   acc_next = acc << shamt;
          OP_SHR:   acc_next = acc >> shamt;
          OP_JMP:   pc_next = jmp_target;
          OP_JZ:    if (acc == '0) pc_next = jmp_target;
          OP_JN:    if (acc[WIDTH-1]) pc_next = jmp_target;
          OP_IN: begin
            pc_next       = pc;
            in_ready_next = 1'b1;
            state_next    = IN_WAIT;
          end
          OP_OUT: begin
            pc_next        = pc;
            out_data_next  = acc;
            out_valid_next = 1'b1;
            state_next     = OUT_WAIT;
          end
          OP_HALT: begin
            pc_next     = pc;
            halted_next = 1'b1;
            state_next  = HALT;
          end
          default: ;
        endcase
      end
      IN_WAIT: begin
        if (in_valid) begin
          acc_next      = in_data;
          pc_next       = pc_inc;
          in_ready_next = 1'b0;
          state_next    = FETCH;
        end
      end
      OUT_WAIT: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          pc_next        = pc_inc;
          state_next     = FETCH;
        end
      end
      HALT: ;
      default: state_next = FETCH;
    endcase
  end

  // State register plus all architectural state; reset overrides any pending handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      halted    <= 1'b0;
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      acc       <= acc_next;
      out_data  <= out_data_next;
      out_valid <= out_valid_next;
      in_ready  <= in_ready_next;
      halted    <= halted_next;
      if (reg_we) regs[reg_addr] <= acc;
    end
  end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Self-checking bench for acc_cpu_core. An instruction-level reference model
// runs alongside the core and is compared every cycle. Directed programs pin
// the model with literal expectations, and random programs with random
// handshakes widen coverage.
module tb_acc_cpu_core;

  localparam int WIDTH = 16;
  localparam int REGS  = 16;
  localparam int PC_W  = 8;
  localparam int ROM_N = 1 << PC_W;

  localparam int PH_FETCH = 0;
  localparam int PH_EXEC  = 1;
  localparam int PH_IN    = 2;
  localparam int PH_OUT   = 3;
  localparam int PH_HALT  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [PC_W-1:0]  imem_addr;
  logic [15:0]      imem_data;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             halted;

  logic [15:0]      rom [ROM_N];
  logic [15:0]      prog_q [$];
  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] dut_outs [$];

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  acc_cpu_core #(.WIDTH(WIDTH), .REGS(REGS), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .halted(halted)
  );

  // Synchronous ROM: data appears one cycle after the address.
  always @(posedge clk) imem_data <= rom[imem_addr];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [15:0] enc(input int opc, input int imm, input int operand);
    return {4'(opc), 1'(imm), 11'(operand)};
  endfunction

  // ---------------- reference model (instruction level) ----------------
  int               m_phase;
  logic [PC_W-1:0]  m_pc;
  logic [WIDTH-1:0] m_acc;
  logic [WIDTH-1:0] m_out_data;
  logic [WIDTH-1:0] m_regs [REGS];
  logic [15:0]      m_ins;
  bit               model_ready = 1'b0;

  assign m_ins = rom[m_pc];

  function automatic logic [WIDTH-1:0] sext11(input logic [10:0] v);
    int s;
    s = int'(v);
    if (s >= 1024) s = s - 2048;
    return WIDTH'(s);
  endfunction

  function automatic logic [WIDTH-1:0] opval(input logic [15:0] ins, input logic [WIDTH-1:0] regval);
    return (ins[11] == 1'b1) ? sext11(ins[10:0]) : regval;
  endfunction

  function automatic logic [WIDTH-1:0] alu(input int opc, input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    case (opc)
      1: return b;
      3: return a + b;
      4: return a - b;
      5: return a & b;
      6: return a | b;
      7: return a ^ b;
      8: return a << (int'(b) % WIDTH);
      9: return a >> (int'(b) % WIDTH);
      default: return a;
    endcase
  endfunction

  function automatic logic [PC_W-1:0] branch_pc(input int opc, input logic [15:0] ins,
                                                input logic [WIDTH-1:0] a, input logic [PC_W-1:0] pc);
    logic [PC_W-1:0] target, seq;
    target = PC_W'(int'(ins[10:0]) % ROM_N);
    seq    = PC_W'((int'(pc) + 1) % ROM_N);
    case (opc)
      10: return target;
      11: return (int'(a) == 0) ? target : seq;
      14: return (int'(a) >= (1 << (WIDTH-1))) ? target : seq;
      default: return seq;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_ready <= 1'b1;
      m_phase     <= PH_FETCH;
      m_pc        <= '0;
      m_acc       <= '0;
      m_out_data  <= '0;
      for (int i = 0; i < REGS; i++) m_regs[i] <= '0;
    end else begin
      case (m_phase)
        PH_FETCH: m_phase <= PH_EXEC;
        PH_EXEC: begin
          case (int'(m_ins[15:12]))
            12: m_phase <= PH_IN;
            13: begin m_out_data <= m_acc; m_phase <= PH_OUT; end
            15: m_phase <= PH_HALT;
            2: begin
              m_regs[int'(m_ins[10:0]) % REGS] <= m_acc;
              m_pc    <= branch_pc(0, m_ins, m_acc, m_pc);
              m_phase <= PH_FETCH;
            end
            default: begin
              m_acc   <= alu(int'(m_ins[15:12]), m_acc,
                             opval(m_ins, m_regs[int'(m_ins[10:0]) % REGS]));
              m_pc    <= branch_pc(int'(m_ins[15:12]), m_ins, m_acc, m_pc);
              m_phase <= PH_FETCH;
            end
          endcase
        end
        PH_IN: if (in_valid) begin
          m_acc   <= in_data;
          m_pc    <= PC_W'((int'(m_pc) + 1) % ROM_N);
          m_phase <= PH_FETCH;
        end
        PH_OUT: if (out_ready) begin
          m_pc    <= PC_W'((int'(m_pc) + 1) % ROM_N);
          m_phase <= PH_FETCH;
        end
        default: ;
      endcase
    end
  end

  // Per-cycle comparison against the model, plus capture of accepted output words.
  always @(negedge clk) begin
    if (model_ready) begin
      checkOutput("imem_addr", 32'(imem_addr), 32'(m_pc));
      checkOutput("in_ready", 32'(in_ready), 32'(m_phase == PH_IN));
      checkOutput("out_valid", 32'(out_valid), 32'(m_phase == PH_OUT));
      checkOutput("out_data", 32'(out_data), 32'(m_out_data));
      checkOutput("halted", 32'(halted), 32'(m_phase == PH_HALT));
      if (out_valid && out_ready && !rst) dut_outs.push_back(out_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic startProgram(input bit fill_halt);
    @(posedge clk); #1;
    rst = 1'b1;
    if (fill_halt) foreach (rom[i]) rom[i] = 16'hF000;
    for (int i = 0; i < prog_q.size() && i < ROM_N; i++) rom[i] = prog_q[i];
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    dut_outs.delete();
  endtask

  task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] id, input logic orr,
                               input logic r);
    @(posedge clk); #1;
    in_valid  = iv;
    in_data   = id;
    out_ready = orr;
    rst       = r;
  endtask

  task automatic runUntilHalt(input int budget, output int valid_cycles);
    valid_cycles = 0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (out_valid) valid_cycles++;
      if (halted) break;
    end
    checkOutput("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic checkOuts(input string name);
    checkOutput({name, "_count"}, 32'(dut_outs.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < dut_outs.size(); i++)
      checkOutput({name, "_word"}, 32'(dut_outs[i]), 32'(exp_q[i]));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int vc;
    foreach (rom[i]) rom[i] = 16'hF000;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_imem_addr", 32'(imem_addr), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_halted", 32'(halted), 32'd0);

    // Program 1: LOAD#5; ADD#-2; OUT; HALT with a sink that is always ready.
    prog_q = '{enc(1,1,5), enc(3,1,-2), enc(13,0,0), enc(15,0,0)};
    out_ready = 1'b1;
    startProgram(1'b1);
    runUntilHalt(100, vc);
    checkOutput("p1_out_valid_cycles", 32'(vc), 32'd1);
    exp_q = '{16'd3};
    checkOuts("p1_out");

    // Program 2: countdown loop emits 3, 2, 1 then halts.
    prog_q = '{enc(1,1,3), enc(13,0,0), enc(4,1,1), enc(11,0,5), enc(10,0,1), enc(15,0,0)};
    startProgram(1'b1);
    runUntilHalt(200, vc);
    exp_q = '{16'd3, 16'd2, 16'd1};
    checkOuts("p2_out");

    // Program 3: IN with in_valid raised three cycles after in_ready rises.
    prog_q = '{enc(12,0,0), enc(13,0,0), enc(15,0,0)};
    in_valid = 1'b0;
    startProgram(1'b1);
    k = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (in_ready) begin
        k++;
        if (k == 4) begin in_valid = 1'b1; in_data = 16'hBEEF; end
      end else if (k > 0) break;
    end
    in_valid = 1'b0;
    checkOutput("p3_in_ready_cycles", 32'(k), 32'd4);
    runUntilHalt(100, vc);
    exp_q = '{16'hBEEF};
    checkOuts("p3_out");

    // Program 4: build 0x1234, OUT while the sink stalls for five cycles.
    prog_q = '{enc(1,1,12'h123), enc(8,1,4), enc(6,1,4), enc(13,0,0), enc(15,0,0)};
    out_ready = 1'b0;
    startProgram(1'b1);
    k = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        k++;
        if (k <= 6) begin
          checkOutput("p4_out_data_stable", 32'(out_data), 32'h1234);
          checkOutput("p4_pc_held", 32'(imem_addr), 32'd3);
        end
        if (k == 6) out_ready = 1'b1;
      end else if (k > 0) break;
    end
    checkOutput("p4_out_valid_cycles", 32'(k), 32'd6);
    runUntilHalt(100, vc);
    exp_q = '{16'h1234};
    checkOuts("p4_out");

    // Program 5: register address wrap and arithmetic overflow wrap.
    prog_q = '{enc(1,1,7), enc(2,0,17), enc(1,1,0), enc(1,0,1), enc(13,0,0),
               enc(1,1,-1), enc(3,1,1), enc(13,0,0), enc(15,0,0)};
    startProgram(1'b1);
    runUntilHalt(200, vc);
    exp_q = '{16'd7, 16'd0};
    checkOuts("p5_out");

    // Program 6: reset lands while OUT is waiting for the sink.
    prog_q = '{enc(1,1,5), enc(3,1,-2), enc(13,0,0), enc(15,0,0)};
    out_ready = 1'b0;
    startProgram(1'b1);
    for (int c = 0; c < 50 && !out_valid; c++) begin @(posedge clk); #1; end
    checkOutput("p6_reached_out_wait", 32'(out_valid), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("p6_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("p6_rst_imem_addr", 32'(imem_addr), 32'd0);
    checkOutput("p6_rst_halted", 32'(halted), 32'd0);
    checkOutput("p6_rst_out_data", 32'(out_data), 32'd0);
    dut_outs.delete();
    out_ready = 1'b1;
    runUntilHalt(100, vc);
    exp_q = '{16'd3};
    checkOuts("p6_out");

    // Random programs with random handshakes and occasional resets.
    for (int p = 0; p < 12; p++) begin
      prog_q.delete();
      for (int i = 0; i < ROM_N; i++)
        prog_q.push_back({4'($urandom_range(0, 14)), 12'($urandom)});
      startProgram(1'b0);
      for (int c = 0; c < 250; c++)
        applyStimulus(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 99) == 0));
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
